axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into one AXI4-Lite read or write transaction. It sits on the initiator side of the multi-port UART register space (8 ports × 8 byte registers, port selected by address bits [5:3]). Typical uses are a local sequencer or test harness driving the UART block without a PCIe host. It supports independent AW/W acceptance, response back-pressure, and carries the read sideband (`aruser`) that the register slave consumes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of `cmd_addr` and `m_awaddr`/`m_araddr`.
- `ARUSER_WIDTH`, default 4: width of `cmd_aruser`/`m_aruser`.

Ports (one clock; reset is synchronous and active-high):
- `aclk`  in  1  clock; all logic rising-edge.
- `areset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write strobes.
- `cmd_aruser`  in  ARUSER_WIDTH  read sideband.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_write`  out  1  echo of the command type.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_resp`  out  2  BRESP or RRESP, passed through unchanged.
- `m_awaddr`/`m_awvalid`/`m_awready`, `m_wdata`/`m_wstrb`/`m_wvalid`/`m_wready`, `m_bresp`/`m_bvalid`/`m_bready`: AXI4-Lite write channels. Widths are ADDR_WIDTH, 32, 4, 2.
- `m_araddr`/`m_aruser`/`m_arvalid`/`m_arready`, `m_rdata`/`m_rresp`/`m_rvalid`/`m_rready`: AXI4-Lite read channels.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, all command fields are registered.
  - Next state is WR_REQ if `cmd_write`, else RD_REQ.
- WR_REQ:
  - `m_awvalid` and `m_wvalid` rise together on entry.
  - Each valid drops individually on the cycle after its own handshake. Per-channel "done" flags track this.
  - Go to WR_RESP once both are done. This includes the case where both complete in the same cycle.
- WR_RESP: `m_bready` = 1. On `m_bvalid`, capture `m_bresp` and force `rsp_rdata` to 0, then go to RSP.
- RD_REQ: `m_arvalid` = 1 with `m_araddr`/`m_aruser` held stable. On `m_arready`, go to RD_RESP.
- RD_RESP: `m_rready` = 1. On `m_rvalid`, capture `m_rdata` and `m_rresp`, then go to RSP.
- RSP:
  - `rsp_valid` = 1 with all `rsp_*` fields stable.
  - On `rsp_ready`, go to IDLE.
  - `cmd_ready` stays 0 throughout RSP; there is no overlap of a new command with a pending response.
- Addresses, data and strobes are not modified. Byte-lane placement for the 8-bit UART registers is the issuer's responsibility.
- Error responses (SLVERR, DECERR) are reported, never retried.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after it. All other outputs are 0: `m_*valid`, `m_bready`, `m_rready`, `rsp_valid`, `rsp_*`, addresses and data.
- Outputs are registered. No combinational path runs from any AXI input to any AXI output.
- Minimum latency with a zero-wait slave (command accepted at edge 0):
  - AW/W or AR valid in cycle 1.
  - B/R handshake no earlier than cycle 2.
  - `rsp_valid` in cycle 3.
  - Next `cmd_ready` in the cycle after `rsp_ready`.
- Valids never deassert before their handshake. Payloads are stable while valid.
- `m_bready`/`m_rready` are asserted only in WR_RESP/RD_RESP. A `bvalid`/`rvalid` arriving in any other state is ignored.
- Reset mid-transaction: next cycle all valids/readys are 0 and the state is IDLE. The slave shares `areset`; no recovery of the in-flight transfer.
- No timeout. A hung slave holds the block in its state indefinitely.

## Structure
- Shared package `axi_lite_pkg`:
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the state enumeration (one-hot localparams).
- Single module; no sub-module is natural. The FSM, capture registers and per-channel done flags fit in about 200 lines.

## Test plan
- Write 0x55 to address 0x0B (port 1, reg 3), strobe 4'b0001; slave is zero-wait.
  - Expect AW/W valid in cycle 1, `rsp_valid` in cycle 3, `rsp_resp`=00, `rsp_rdata`=0.
- Same write with `awready` delayed 3 cycles and `wready` immediate.
  - Expect `wvalid` to drop after 1 cycle and `awvalid` to hold 4 cycles.
  - Expect exactly one AW and one W handshake, and `rsp_valid` 2 cycles after the AW handshake.
- Read 0x3D with `aruser`=4'hA, and the slave returns 0x000000A5 OKAY after 2 wait cycles.
  - Expect `m_aruser`=4'hA during AR, `rsp_rdata`=0xA5, `rsp_resp`=00.
- Slave returns RRESP=SLVERR.
  - Expect `rsp_resp`=2'b10 with no retry.
  - Expect `cmd_ready` back after `rsp_ready`.
- Hold `rsp_ready` low 5 cycles with `cmd_valid` held high.
  - Expect `rsp_*` stable throughout, `cmd_ready`=0, and no new AXI activity until the response is consumed.
- Assert `areset` for 1 cycle while in WR_REQ with AW pending.
  - Expect all valids at 0 the next cycle, IDLE, `cmd_ready`=1 afterwards.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel widths and the
// command-master state encoding.
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  localparam int unsigned STATE_W = 6;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 6'b000001,
    ST_WR_REQ  = 6'b000010,
    ST_WR_RESP = 6'b000100,
    ST_RD_REQ  = 6'b001000,
    ST_RD_RESP = 6'b010000,
    ST_RSP     = 6'b100000
  } state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI read or
// write out, one response back. All outputs are registered.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned ARUSER_WIDTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]       cmd_wdata,
  input  logic [STRB_W-1:0]       cmd_wstrb,
  input  logic [ARUSER_WIDTH-1:0] cmd_aruser,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [RESP_W-1:0]       rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [STRB_W-1:0]       m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [RESP_W-1:0]       m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [ARUSER_WIDTH-1:0] m_aruser,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [RESP_W-1:0]       m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  state_e state;
  logic   aw_done;
  logic   w_done;

  logic aw_hs_c;
  logic w_hs_c;

  assign aw_hs_c = m_awvalid & m_awready;
  assign w_hs_c  = m_wvalid & m_wready;

  // AW and W complete independently; leave WR_REQ once both have been taken.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_aruser  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_awaddr  <= cmd_addr;
              m_wdata   <= cmd_wdata;
              m_wstrb   <= cmd_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= ST_WR_REQ;
            end else begin
              m_araddr  <= cmd_addr;
              m_aruser  <= cmd_aruser;
              m_arvalid <= 1'b1;
              state     <= ST_RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs_c) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs_c) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) begin
            m_bready <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_bresp;
            state     <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // New commands wait until the pending response is consumed.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized bench for axi_lite_cmd_master: a delay-programmable register
// slave plus a word-array reference model of the UART register space.
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb, cmd_aruser;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb, m_aruser;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  always #5 aclk = ~aclk;

  axi_lite_cmd_master #(.ADDR_WIDTH(32), .ARUSER_WIDTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .cmd_aruser(cmd_aruser),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_aruser(m_aruser), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Slave knobs: wait cycles per channel and the response code to return.
  int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0]  resp_sel;

  // Slave observations.
  int          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb, cap_aruser;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  // Slave runs on the falling edge: decisions made here hold through the next rising edge.
  initial begin : slave
    int  aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit  aw_got, w_got, wr_pend, rd_pend, b_fire, r_fire;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0; cap_wstrb = '0; cap_aruser = '0;
    for (int i = 0; i < 16; i++) slv_mem[i] = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0; b_fire = 0; r_fire = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_rvalid = 1'b0;
        aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
        if (b_fire) begin m_bvalid = 1'b0; b_fire = 0; end
        if (r_fire) begin m_rvalid = 1'b0; r_fire = 0; end
        if (wr_pend) begin
          if (b_wait >= b_dly) begin
            m_bvalid = 1'b1;
            m_bresp  = resp_sel;
            if (resp_sel == RESP_OKAY)
              for (int b = 0; b < 4; b++)
                if (cap_wstrb[b]) slv_mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
            wr_pend = 0; b_wait = 0;
          end else b_wait++;
        end
        if (rd_pend) begin
          if (r_wait >= r_dly) begin
            m_rvalid = 1'b1;
            m_rdata  = slv_mem[cap_araddr[5:2]];
            m_rresp  = resp_sel;
            rd_pend = 0; r_wait = 0;
          end else r_wait++;
        end
        if (m_bvalid && m_bready) begin b_fire = 1; b_hs++; end
        if (m_rvalid && m_rready) begin r_fire = 1; r_hs++; end
        m_awready = 1'b0;
        if (m_awvalid && !aw_got) begin
          if (aw_wait >= aw_dly) begin
            m_awready = 1'b1; cap_awaddr = m_awaddr; aw_got = 1; aw_hs++; aw_wait = 0;
          end else aw_wait++;
        end
        m_wready = 1'b0;
        if (m_wvalid && !w_got) begin
          if (w_wait >= w_dly) begin
            m_wready = 1'b1; cap_wdata = m_wdata; cap_wstrb = m_wstrb; w_got = 1; w_hs++; w_wait = 0;
          end else w_wait++;
        end
        if (aw_got && w_got) begin wr_pend = 1; aw_got = 0; w_got = 0; end
        m_arready = 1'b0;
        if (m_arvalid && !rd_pend && !m_rvalid) begin
          if (ar_wait >= ar_dly) begin
            m_arready = 1'b1; cap_araddr = m_araddr; cap_aruser = m_aruser;
            rd_pend = 1; ar_hs++; ar_wait = 0;
          end else ar_wait++;
        end
      end
    end
  end

  task automatic set_knobs(input int a, input int w, input int ar, input int b, input int r);
    aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
  endtask

  // Issue one command and check timing, AXI payloads and the response.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [3:0] user,
                        input int hold, input bit keep);
    int          cyc, guard, aw_hi, w_hi, ar_hi, exp_lat;
    int          aw0, w0, ar0, b0, r0;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs; r0 = r_hs;
    exp_resp = resp_sel;
    if (wr) begin
      exp_rdata = '0;
      exp_lat   = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
      if (resp_sel == RESP_OKAY)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      exp_rdata = ref_mem[addr[5:2]];
      exp_lat   = ar_dly + r_dly + 3;
    end
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_aruser = user;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge aclk); guard++; end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 64'(0), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(negedge aclk);
    if (!keep) cmd_valid = 1'b0;
    cyc = 1; aw_hi = 0; w_hi = 0; ar_hi = 0;
    chk(wr ? "aw_w_valid_c1" : "ar_valid_c1",
        64'(wr ? (m_awvalid & m_wvalid) : m_arvalid), 64'(1));
    while (!rsp_valid && cyc < 200) begin
      if (m_awvalid) aw_hi++;
      if (m_wvalid)  w_hi++;
      if (m_arvalid) ar_hi++;
      @(negedge aclk);
      cyc++;
    end
    chk("rsp_latency", 64'(cyc), 64'(exp_lat));
    if (wr) begin
      chk("awvalid_cycles", 64'(aw_hi), 64'(aw_dly + 1));
      chk("wvalid_cycles", 64'(w_hi), 64'(w_dly + 1));
    end else begin
      chk("arvalid_cycles", 64'(ar_hi), 64'(ar_dly + 1));
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("hold_rsp_resp", 64'(rsp_resp), 64'(exp_resp));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("hold_axi_idle", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 64'(0));
      @(negedge aclk);
    end
    chk("rsp_write", 64'(rsp_write), 64'(wr));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
    rsp_ready = 1'b1;
    if (keep) cmd_valid = 1'b0;
    @(negedge aclk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_back", 64'(cmd_ready), 64'(1));
    if (wr) begin
      chk("aw_handshakes", 64'(aw_hs - aw0), 64'(1));
      chk("w_handshakes", 64'(w_hs - w0), 64'(1));
      chk("b_handshakes", 64'(b_hs - b0), 64'(1));
      chk("awaddr", 64'(cap_awaddr), 64'(addr));
      chk("wdata", 64'(cap_wdata), 64'(wdata));
      chk("wstrb", 64'(cap_wstrb), 64'(strb));
    end else begin
      chk("ar_handshakes", 64'(ar_hs - ar0), 64'(1));
      chk("r_handshakes", 64'(r_hs - r0), 64'(1));
      chk("araddr", 64'(cap_araddr), 64'(addr));
      chk("aruser", 64'(cap_aruser), 64'(user));
    end
    chk("no_stray_channel", 64'(wr ? (ar_hs - ar0) : (aw_hs - aw0 + w_hs - w0)), 64'(0));
  endtask

  initial begin
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_aruser = '0; rsp_ready = 1'b0;
    resp_sel = RESP_OKAY;
    set_knobs(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    @(negedge aclk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_valids", 64'({m_awvalid, m_wvalid, m_arvalid, rsp_valid}), 64'(0));
    chk("reset_readys", 64'({m_bready, m_rready}), 64'(0));
    chk("reset_payload", 64'(m_awaddr | m_wdata | m_araddr | rsp_rdata), 64'(0));
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));

    // Zero-wait write, then the same write with AW stalled three cycles.
    do_cmd(1'b1, 32'h0000_000B, 32'h0000_0055, 4'b0001, 4'h0, 0, 1'b0);
    set_knobs(3, 0, 0, 0, 0);
    do_cmd(1'b1, 32'h0000_000B, 32'h0000_0055, 4'b0001, 4'h0, 0, 1'b0);

    // Seed 0x3C then read it back through 0x3D with sideband and two R wait cycles.
    set_knobs(0, 0, 0, 0, 0);
    do_cmd(1'b1, 32'h0000_003C, 32'h0000_00A5, 4'hF, 4'h0, 0, 1'b0);
    set_knobs(0, 0, 0, 0, 2);
    do_cmd(1'b0, 32'h0000_003D, 32'h0, 4'h0, 4'hA, 0, 1'b0);

    // Error response is passed through once.
    resp_sel = RESP_SLVERR;
    set_knobs(0, 0, 1, 0, 1);
    do_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 4'h5, 0, 1'b0);

    // Response back-pressure with a new command already waiting.
    resp_sel = RESP_OKAY;
    set_knobs(1, 2, 0, 1, 0);
    do_cmd(1'b1, 32'h0000_0021, 32'hDEAD_BEEF, 4'b0110, 4'h0, 5, 1'b1);

    // Reset while AW is still pending; the write must not land.
    set_knobs(5, 0, 0, 0, 0);
    cmd_write = 1'b1; cmd_addr = 32'h0000_003C; cmd_wdata = 32'h1234_5678;
    cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("pre_reset_awvalid", 64'(m_awvalid), 64'(1));
    @(posedge aclk);
    #1 areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("midreset_valids", 64'({m_awvalid, m_wvalid, m_arvalid, rsp_valid}), 64'(0));
    chk("midreset_readys", 64'({m_bready, m_rready}), 64'(0));
    @(negedge aclk);
    chk("midreset_cmd_ready", 64'(cmd_ready), 64'(1));
    set_knobs(0, 0, 0, 0, 0);
    do_cmd(1'b0, 32'h0000_003C, 32'h0, 4'h0, 4'h3, 0, 1'b0);

    // Random traffic across the register space and slave timings.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s, u;
      a = $urandom; d = $urandom;
      s = 4'($urandom_range(15, 0));
      u = 4'($urandom_range(15, 0));
      set_knobs($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(3, 0));
      resp_sel = 2'($urandom_range(3, 0));
      do_cmd(1'($urandom_range(1, 0)), a, d, s, u, $urandom_range(2, 0),
             1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
